ervp_pulse_request_arbiter: RTL and testbench

Captures one-cycle request pulses from NUM_REQ independent requesters and holds each as a sticky pending bit until serviced. Issues serialized, round-robin grants to a single shared resource, and waits for the resource's one-cycle completion pulse before the next grant. It is the sequencer placed in front of any shared engine whose requesters signal with single-cycle valid events.

---
 rtl/ervp_pulse_request_arbiter_pkg.sv | 17 +
 rtl/ervp_pulse_request_arbiter_if.sv | 27 ++
 rtl/ervp_rr_pick.sv | 27 ++
 rtl/ervp_pulse_request_arbiter.sv | 100 ++++++++++
 tb/tb_ervp_pulse_request_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ervp_pulse_request_arbiter_pkg.sv
// Shared definitions for the pulse request arbiter: FSM encoding, default
// requester count and the round-robin pointer wrap helper.
package ervp_pulse_arb_pkg;

    localparam int NUM_REQ_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned limit);
        return (idx + 1 >= limit) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ervp_pulse_request_arbiter_if.sv
// Request/grant/completion bundle between requesters, the arbiter and the
// shared resource. The arbiter uses the slave modport.
interface ervp_pulse_request_arbiter_if
    import ervp_pulse_arb_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEFAULT,
    parameter int INDEX_WIDTH = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]     req_once;
    logic [NUM_REQ-1:0]     pending;
    logic [NUM_REQ-1:0]     dropped;
    logic                   grant_valid;
    logic [INDEX_WIDTH-1:0] grant_index;
    logic                   grant_ready;
    logic                   done_once;
    logic                   busy;

    modport slave (
        input  req_once, grant_ready, done_once,
        output pending, dropped, grant_valid, grant_index, busy
    );

    modport master (
        output req_once, grant_ready, done_once,
        input  pending, dropped, grant_valid, grant_index, busy
    );
endinterface

// File: rtl/ervp_rr_pick.sv
// Combinational round-robin picker: first set bit of pending at or above
// rr_ptr, wrapping modulo NUM_REQ.
module ervp_rr_pick #(
    parameter int NUM_REQ     = 4,
    parameter int INDEX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]     pending,
    input  logic [INDEX_WIDTH-1:0] rr_ptr,
    output logic                   found,
    output logic [INDEX_WIDTH-1:0] index
);
    always_comb begin
        int slot;
        // NOTE: every output gets a default before the loop so no latch is inferred.
        found = 1'b0;
        index = '0;
        slot  = 0;
        // Scan from the farthest offset down so the nearest hit is written last.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            slot = (int'(rr_ptr) + off) % NUM_REQ;
            if (pending[slot]) begin
                found = 1'b1;
                index = INDEX_WIDTH'(slot);
            end
        end
    end
endmodule

// File: rtl/ervp_pulse_request_arbiter.sv
// Captures single-cycle request pulses as sticky pending bits and issues
// serialized round-robin grants, one outstanding at a time.
module ervp_pulse_request_arbiter
    import ervp_pulse_arb_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEFAULT,
    parameter int INDEX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    ervp_pulse_request_arbiter_if.slave bus
);
    arb_state_e             state_q, state_d;
    logic [NUM_REQ-1:0]     pending_q, pending_d;
    logic [NUM_REQ-1:0]     dropped_q, dropped_d;
    logic [NUM_REQ-1:0]     accept_vec;
    logic                   grant_valid_q, grant_valid_d;
    logic                   busy_q, busy_d;
    logic [INDEX_WIDTH-1:0] grant_index_q, grant_index_d;
    logic [INDEX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [INDEX_WIDTH-1:0] pick_index;
    logic                   pick_found;
    logic                   accept;

    ervp_rr_pick #(
        .NUM_REQ     (NUM_REQ),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_pick (
        .pending (pending_q),
        .rr_ptr  (rr_ptr_q),
        .found   (pick_found),
        .index   (pick_index)
    );

    // grant_valid_q is only ever high in ISSUE, so it qualifies acceptance.
    assign accept = grant_valid_q & bus.grant_ready;

    always_comb begin
        accept_vec = '0;
        if (accept) accept_vec[grant_index_q] = 1'b1;
        // A new pulse wins over the acceptance clear and is not a drop.
        pending_d = (pending_q & ~accept_vec) | bus.req_once;
        dropped_d = dropped_q | (bus.req_once & pending_q & ~accept_vec);
    end

    always_comb begin
        state_d       = state_q;
        grant_index_d = grant_index_q;
        rr_ptr_d      = rr_ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && pick_found) begin
                    state_d       = ST_ISSUE;
                    grant_index_d = pick_index;
                end
            end
            ST_ISSUE: begin
                if (bus.grant_ready) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (bus.done_once) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = INDEX_WIDTH'(wrap_inc(32'(grant_index_q), 32'(NUM_REQ)));
                end
            end
            default: state_d = ST_IDLE;
        endcase
        grant_valid_d = (state_d == ST_ISSUE);
        busy_d        = (state_d != ST_IDLE);
    end

    // NOTE: state flops use non-blocking assignments; reset and clear are sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q       <= ST_IDLE;
            pending_q     <= '0;
            dropped_q     <= '0;
            grant_valid_q <= 1'b0;
            grant_index_q <= '0;
            busy_q        <= 1'b0;
            rr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            dropped_q     <= dropped_d;
            grant_valid_q <= grant_valid_d;
            grant_index_q <= grant_index_d;
            busy_q        <= busy_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign bus.pending     = pending_q;
    assign bus.dropped     = dropped_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_index = grant_index_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_ervp_pulse_request_arbiter.sv
// Bench for ervp_pulse_request_arbiter: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_ervp_pulse_request_arbiter;
    localparam int N = 4;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst, clear, enable;
    int   n_tests = 0;
    int   n_fail  = 0;

    ervp_pulse_request_arbiter_if #(.NUM_REQ(N), .INDEX_WIDTH(W)) bus ();

    ervp_pulse_request_arbiter #(.NUM_REQ(N), .INDEX_WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .enable (enable),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic         rdy, done, en, clr;
        logic [N-1:0] pend, drop;
        logic         gv;
        logic [W-1:0] gi;
        logic         busy;
    } vec_t;

    // Model: phase 0 = nothing offered, 1 = grant offered, 2 = resource working.
    logic [N-1:0] m_pend, m_drop;
    int           m_phase, m_gi, m_ptr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic [N-1:0] old_pend;
        bit           acc, taken, hit;
        int           slot;
        if (rst || clear) begin
            m_pend = '0; m_drop = '0; m_phase = 0; m_gi = 0; m_ptr = 0;
            return;
        end
        old_pend = m_pend;
        acc = (m_phase == 1) && bus.grant_ready;
        for (int i = 0; i < N; i++) begin
            taken = acc && (m_gi == i);
            if (bus.req_once[i] && old_pend[i] && !taken) m_drop[i] = 1'b1;
            m_pend[i] = bus.req_once[i] || (old_pend[i] && !taken);
        end
        case (m_phase)
            0: if (enable && old_pend != '0) begin
                hit = 1'b0;
                for (int k = 0; k < N; k++) begin
                    slot = (m_ptr + k) % N;
                    if (!hit && old_pend[slot]) begin
                        m_gi = slot;
                        hit  = 1'b1;
                    end
                end
                m_phase = 1;
            end
            1: if (bus.grant_ready) m_phase = 2;
            default: if (bus.done_once) begin
                m_phase = 0;
                m_ptr   = (m_gi + 1) % N;
            end
        endcase
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pending"}, 32'(bus.pending), 32'(m_pend));
        check({tag, ".dropped"}, 32'(bus.dropped), 32'(m_drop));
        check({tag, ".grant_valid"}, 32'(bus.grant_valid), 32'(m_phase == 1));
        check({tag, ".grant_index"}, 32'(bus.grant_index), 32'(m_gi));
        check({tag, ".busy"}, 32'(bus.busy), 32'(m_phase != 0));
    endtask

    task automatic drive(input logic [N-1:0] r, input logic rdy, input logic d,
                         input logic en, input logic clr);
        bus.req_once    = r;
        bus.grant_ready = rdy;
        bus.done_once   = d;
        enable          = en;
        clear           = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic vec_t mk(input logic [N-1:0] req, input logic rdy, input logic done,
                                input logic en, input logic clr, input logic [N-1:0] pend,
                                input logic [N-1:0] drop, input logic gv, input logic [W-1:0] gi,
                                input logic busy);
        vec_t v;
        v.req = req; v.rdy = rdy; v.done = done; v.en = en; v.clr = clr;
        v.pend = pend; v.drop = drop; v.gv = gv; v.gi = gi; v.busy = busy;
        return v;
    endfunction

    initial begin
        vec_t vecs[$];
        int   order[$];
        int   pos;

        rst = 1'b1;
        drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        check("reset.pending", 32'(bus.pending), 32'd0);
        check("reset.dropped", 32'(bus.dropped), 32'd0);
        check("reset.grant_valid", 32'(bus.grant_valid), 32'd0);
        check("reset.grant_index", 32'(bus.grant_index), 32'd0);
        check("reset.busy", 32'(bus.busy), 32'd0);

        //             req     rdy   done  en    clr  | pend    drop    gv    gi     busy
        vecs.push_back(mk(4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0));
        vecs.push_back(mk(4'b1001, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1001, 4'b0000, 1'b0, 2'd2, 1'b0));
        vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1001, 4'b0000, 1'b1, 2'd3, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 2'd3, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 2'd3, 1'b0));
        vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0));
        vecs.push_back(mk(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0));
        vecs.push_back(mk(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0));
        vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0));
        vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b1));
        vecs.push_back(mk(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0));
        vecs.push_back(mk(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b0));
        vecs.push_back(mk(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 2'd1, 1'b0));
        vecs.push_back(mk(4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0));

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].rdy, vecs[i].done, vecs[i].en, vecs[i].clr);
            tick();
            check($sformatf("vec%0d.pending", i), 32'(bus.pending), 32'(vecs[i].pend));
            check($sformatf("vec%0d.dropped", i), 32'(bus.dropped), 32'(vecs[i].drop));
            check($sformatf("vec%0d.grant_valid", i), 32'(bus.grant_valid), 32'(vecs[i].gv));
            check($sformatf("vec%0d.grant_index", i), 32'(bus.grant_index), 32'(vecs[i].gi));
            check($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(vecs[i].busy));
        end

        // Round-robin over all four requesters from a single burst.
        drive(4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            if (bus.grant_valid) order.push_back(int'(bus.grant_index));
            drive('0, 1'b1, 1'b1, 1'b1, 1'b0);
            tick();
            check_model("rr");
        end
        check("rr.grant_count", 32'(order.size()), 32'd4);
        foreach (order[i]) check($sformatf("rr.order%0d", i), 32'(order[i]), 32'(i));
        drive('0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check("rr.pending_empty", 32'(bus.pending), 32'd0);
        check("rr.no_drops", 32'(bus.dropped), 32'd0);

        // Set beats clear: re-pulse on the acceptance cycle.
        drive(4'b0010, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive('0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("sbc.first_grant_index", 32'(bus.grant_index), 32'd1);
        drive(4'b0010, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("sbc.pending_kept", 32'(bus.pending), 32'b0010);
        check("sbc.no_drop", 32'(bus.dropped), 32'd0);
        check("sbc.busy", 32'(bus.busy), 32'd1);
        drive('0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive('0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("sbc.regrant_valid", 32'(bus.grant_valid), 32'd1);
        check("sbc.regrant_index", 32'(bus.grant_index), 32'd1);

        // Stall in ISSUE; enable dropping must not withdraw the grant.
        for (int k = 0; k < 5; k++) begin
            drive('0, 1'b0, 1'b0, logic'(k % 2), 1'b0);
            tick();
            check($sformatf("stall%0d.grant_valid", k), 32'(bus.grant_valid), 32'd1);
            check($sformatf("stall%0d.grant_index", k), 32'(bus.grant_index), 32'd1);
        end
        drive('0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("stall.accepted_busy", 32'(bus.busy), 32'd1);
        check("stall.accepted_gv", 32'(bus.grant_valid), 32'd0);

        // Clear while BUSY; late done is ignored and the pointer restarts at 0.
        drive('0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check_model("clr");
        check("clr.busy", 32'(bus.busy), 32'd0);
        check("clr.grant_index", 32'(bus.grant_index), 32'd0);
        drive('0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check("clr.late_done_busy", 32'(bus.busy), 32'd0);
        check("clr.late_done_gv", 32'(bus.grant_valid), 32'd0);
        drive(4'b1001, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive('0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("clr.regrant_valid", 32'(bus.grant_valid), 32'd1);
        check("clr.regrant_index", 32'(bus.grant_index), 32'd0);
        drive('0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();

        // Fairness: requester 0 pulses every cycle, requester 1 once.
        order.delete();
        drive(4'b0011, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        for (int c = 0; c < 30 && order.size() < 3; c++) begin
            if (bus.grant_valid) order.push_back(int'(bus.grant_index));
            drive(4'b0001, 1'b1, 1'b1, 1'b1, 1'b0);
            tick();
            check_model("fair");
        end
        pos = -1;
        foreach (order[i]) if (pos < 0 && order[i] == 1) pos = i;
        check("fair.req1_position", 32'(pos), 32'd1);
        drive('0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] r;
            for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 299) == 0);
            drive(r, logic'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 4) != 0), ($urandom_range(0, 149) == 0));
            tick();
            check_model("rand");
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
